instr_enc: RTL

- MSP430 instruction encoder; the producer side of the instruction-word stream that instr_dec consumes.
- Accepts one decoded instruction descriptor via valid/ready.
- Emits the 1–3 word encoding (instruction word, then source extension, then destination extension) as a word stream, each word tagged with its byte address.
- Used to build ROM images and program-memory loaders, and as the stimulus source for instr_dec.

---
 rtl/instr_enc_pkg.sv | 60 ++++++
 rtl/instr_enc_word.sv | 83 ++++++++
 rtl/instr_enc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: shared constants and types for the MSP430 instruction encoder.
//   - instruction format codes carried on in_fmt
//   - format-II opcodes the encoder treats specially (PUSH, CALL, RETI, reserved)
//   - constant-generator registers / addressing modes and the CG lookup
//   - encoder FSM state encoding
package instr_enc_pkg;

    localparam logic [1:0] FMT_I  = 2'd1;
    localparam logic [1:0] FMT_II = 2'd2;
    localparam logic [1:0] FMT_J  = 2'd3;

    localparam logic [2:0] OP2_PUSH = 3'd4;
    localparam logic [2:0] OP2_CALL = 3'd5;
    localparam logic [2:0] OP2_RETI = 3'd6;
    localparam logic [2:0] OP2_RSVD = 3'd7;

    localparam logic [15:0] RETI_WORD     = 16'h1300;
    localparam logic [5:0]  FMT_II_PREFIX = 6'b000100;
    localparam logic [2:0]  FMT_J_PREFIX  = 3'b001;

    localparam logic [3:0] REG_PC = 4'd0;
    localparam logic [3:0] REG_SR = 4'd2;
    localparam logic [3:0] REG_CG = 4'd3;

    localparam logic [1:0] AS_REG = 2'd0;
    localparam logic [1:0] AS_IDX = 2'd1;
    localparam logic [1:0] AS_IND = 2'd2;
    localparam logic [1:0] AS_INC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WORD0   = 2'd1,
        ST_SRC_EXT = 2'd2,
        ST_DST_EXT = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] rn;
        logic [1:0] as_mode;
    } cg_sub_t;

    // Immediate values the hardware constant generators can produce, and the
    // register/mode pair that yields each one without an extension word.
    function automatic cg_sub_t cg_map(input logic [15:0] val);
        cg_sub_t s;
        s = '{hit: 1'b1, rn: REG_CG, as_mode: AS_REG};
        case (val)
            16'h0000: s.as_mode = AS_REG;
            16'h0001: s.as_mode = AS_IDX;
            16'h0002: s.as_mode = AS_IND;
            16'hFFFF: s.as_mode = AS_INC;
            16'h0004: begin s.rn = REG_SR; s.as_mode = AS_IND; end
            16'h0008: begin s.rn = REG_SR; s.as_mode = AS_INC; end
            default:  s.hit = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/instr_enc_word.sv
// instr_enc_word: combinational encoding of one instruction descriptor.
// Inputs : fmt/op/bw/as_mode/ad/src/dst descriptor fields, src_ext (immediate,
//          also the CG key), target (jump byte address), pc (address of the
//          instruction word), cg_en (CG substitution enable).
// Outputs: word0 (instruction word), need_src / need_dst (extension words
//          follow), len (total words 1..3), err (descriptor cannot be encoded).
module instr_enc_word
    import instr_enc_pkg::*;
(
    input  logic [1:0]  fmt,
    input  logic [3:0]  op,
    input  logic        bw,
    input  logic [1:0]  as_mode,
    input  logic        ad,
    input  logic [3:0]  src,
    input  logic [3:0]  dst,
    input  logic [15:0] src_ext,
    input  logic [15:0] target,
    input  logic [15:0] pc,
    input  logic        cg_en,
    output logic [15:0] word0,
    output logic        need_src,
    output logic        need_dst,
    output logic [1:0]  len,
    output logic        err
);

    cg_sub_t     sub;
    logic [3:0]  rn;
    logic [1:0]  am;
    logic [15:0] diff;
    logic        cg_allowed;
    logic        ext_rule;

    always_comb begin
        word0      = '0;
        need_src   = 1'b0;
        need_dst   = 1'b0;
        err        = 1'b0;
        sub        = cg_map(src_ext);
        diff       = target - (pc + 16'd2);
        // Format II carries its single operand in the dst field.
        rn         = (fmt == FMT_II) ? dst : src;
        am         = as_mode;
        cg_allowed = (fmt == FMT_I) ||
                     ((fmt == FMT_II) && ((op[2:0] == OP2_PUSH) || (op[2:0] == OP2_CALL)));

        if (cg_en && cg_allowed && (as_mode == AS_INC) && (rn == REG_PC) && sub.hit) begin
            rn = sub.rn;
            am = sub.as_mode;
        end

        // Indexed/symbolic/absolute (but not R3 = #1) and @PC+ immediates carry a word.
        ext_rule = ((am == AS_IDX) && (rn != REG_CG)) || ((am == AS_INC) && (rn == REG_PC));

        case (fmt)
            FMT_I: begin
                word0    = {op, rn, ad, bw, am, dst};
                need_src = ext_rule;
                need_dst = ad;
            end
            FMT_II: begin
                if (op[2:0] == OP2_RETI) begin
                    word0 = RETI_WORD;
                end else if (op[2:0] == OP2_RSVD) begin
                    err = 1'b1;
                end else begin
                    word0    = {FMT_II_PREFIX, op[2:0], bw, am, rn};
                    need_src = ext_rule;
                end
            end
            FMT_J: begin
                word0 = {FMT_J_PREFIX, op[2:0], diff[10:1]};
                // Word offset must fit signed 10 bits: bits 15..10 are all sign copies.
                err   = diff[0] | (diff[15:10] != {6{diff[10]}});
            end
            default: err = 1'b1;
        endcase

        len = 2'd1 + {1'b0, need_src} + {1'b0, need_dst};
    end

endmodule

// File: rtl/instr_enc.sv
// instr_enc: MSP430 instruction encoder; accepts one descriptor per handshake
// and streams its 1..3 words, each tagged with its byte address.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready, in_*     descriptor input handshake and fields
//   cg_en                       constant-generator substitution enable
//   addr_load/addr_in           reload the address counter (IDLE only)
//   out_valid/out_ready         word output handshake
//   out_word/out_addr           encoded word and its byte address
//   out_last/out_len            final-word flag and instruction length
//   err                         one-cycle pulse: descriptor rejected
//
// state      | meaning
// ST_IDLE    | ready for a descriptor or an address load
// ST_WORD0   | presenting the instruction word
// ST_SRC_EXT | presenting the source extension / immediate
// ST_DST_EXT | presenting the destination extension
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hC000,
    parameter logic        CG_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [3:0]  in_op,
    input  logic        in_bw,
    input  logic [1:0]  in_as,
    input  logic        in_ad,
    input  logic [3:0]  in_src,
    input  logic [3:0]  in_dst,
    input  logic [15:0] in_src_ext,
    input  logic [15:0] in_dst_ext,
    input  logic [15:0] in_target,
    input  logic        cg_en,
    input  logic        addr_load,
    input  logic [15:0] addr_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [15:0] out_addr,
    output logic        out_last,
    output logic [1:0]  out_len,
    output logic        err
);

    enc_state_t  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] word0_q, word0_d;
    logic [15:0] src_ext_q, src_ext_d;
    logic [15:0] dst_ext_q, dst_ext_d;
    logic        need_src_q, need_src_d;
    logic        need_dst_q, need_dst_d;
    logic [1:0]  len_q, len_d;
    logic        err_q, err_d;
    logic        cg_q, cg_d;

    logic [15:0] w_word0;
    logic        w_need_src;
    logic        w_need_dst;
    logic [1:0]  w_len;
    logic        w_err;
    logic        cg_eff;
    logic        accept;
    logic        handshake;

    // cg_q holds CG_DEFAULT until the first clock after reset, then mirrors cg_en.
    assign cg_eff = cg_en | cg_q;

    instr_enc_word u_word (
        .fmt      (in_fmt),
        .op       (in_op),
        .bw       (in_bw),
        .as_mode  (in_as),
        .ad       (in_ad),
        .src      (in_src),
        .dst      (in_dst),
        .src_ext  (in_src_ext),
        .target   (in_target),
        .pc       (addr_q),
        .cg_en    (cg_eff),
        .word0    (w_word0),
        .need_src (w_need_src),
        .need_dst (w_need_dst),
        .len      (w_len),
        .err      (w_err)
    );

    assign in_ready  = (state_q == ST_IDLE) && !addr_load;
    assign out_valid = (state_q != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign out_addr  = addr_q;
    assign err       = err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word0_d    = word0_q;
        src_ext_d  = src_ext_q;
        dst_ext_d  = dst_ext_q;
        need_src_d = need_src_q;
        need_dst_d = need_dst_q;
        len_d      = len_q;
        err_d      = 1'b0;
        cg_d       = cg_en;

        case (state_q)
            ST_IDLE: begin
                if (addr_load) begin
                    addr_d = addr_in & 16'hFFFE;
                end else if (accept) begin
                    if (w_err) begin
                        err_d = 1'b1;
                    end else begin
                        word0_d    = w_word0;
                        src_ext_d  = in_src_ext;
                        dst_ext_d  = in_dst_ext;
                        need_src_d = w_need_src;
                        need_dst_d = w_need_dst;
                        len_d      = w_len;
                        state_d    = ST_WORD0;
                    end
                end
            end
            ST_WORD0: begin
                if (handshake) begin
                    addr_d = addr_q + 16'd2;
                    if (need_src_q)      state_d = ST_SRC_EXT;
                    else if (need_dst_q) state_d = ST_DST_EXT;
                    else                 state_d = ST_IDLE;
                end
            end
            ST_SRC_EXT: begin
                if (handshake) begin
                    addr_d  = addr_q + 16'd2;
                    state_d = need_dst_q ? ST_DST_EXT : ST_IDLE;
                end
            end
            ST_DST_EXT: begin
                if (handshake) begin
                    addr_d  = addr_q + 16'd2;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_word = '0;
        out_last = 1'b0;
        out_len  = 2'd0;
        case (state_q)
            ST_WORD0: begin
                out_word = word0_q;
                out_last = !need_src_q && !need_dst_q;
                out_len  = len_q;
            end
            ST_SRC_EXT: begin
                out_word = src_ext_q;
                out_last = !need_dst_q;
                out_len  = len_q;
            end
            ST_DST_EXT: begin
                out_word = dst_ext_q;
                out_last = 1'b1;
                out_len  = len_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            word0_q    <= '0;
            src_ext_q  <= '0;
            dst_ext_q  <= '0;
            need_src_q <= 1'b0;
            need_dst_q <= 1'b0;
            len_q      <= 2'd0;
            err_q      <= 1'b0;
            cg_q       <= CG_DEFAULT;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word0_q    <= word0_d;
            src_ext_q  <= src_ext_d;
            dst_ext_q  <= dst_ext_d;
            need_src_q <= need_src_d;
            need_dst_q <= need_dst_d;
            len_q      <= len_d;
            err_q      <= err_d;
            cg_q       <= cg_d;
        end
    end

endmodule
